// File: rtl/sha2_msg_sched.sv
// SHA-2 message scheduler: loads one 16-word block, then expands it into the
// W_t stream through a 16-entry ring, with valid/yumi handshakes on both sides.
module sha2_msg_sched #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned IDX_W  = $clog2(ROUNDS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              m_v_i,
    input  logic [WORD_W-1:0] m_data_i,
    output logic              m_ready_o,
    output logic              wt_v_o,
    output logic [WORD_W-1:0] wt_o,
    output logic [IDX_W-1:0]  wt_idx_o,
    input  logic              wt_yumi_i,
    output logic              busy_o,
    output logic              done_o
);

    if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
        $error("sha2_msg_sched: WORD_W must be 32 or 64");
    end

    // t must be able to sit at ROUNDS once the last word has been generated
    localparam int unsigned CNT_W   = $clog2(ROUNDS + 1);
    localparam int unsigned RING_N  = 16;
    localparam int unsigned RIDX_W  = 4;
    localparam int unsigned LAST_LD = RING_N - 1;

    localparam int unsigned S0_A = (WORD_W == 64) ? 1  : 7;
    localparam int unsigned S0_B = (WORD_W == 64) ? 8  : 18;
    localparam int unsigned S0_C = (WORD_W == 64) ? 7  : 3;
    localparam int unsigned S1_A = (WORD_W == 64) ? 19 : 17;
    localparam int unsigned S1_B = (WORD_W == 64) ? 61 : 19;
    localparam int unsigned S1_C = (WORD_W == 64) ? 6  : 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2
    } state_e;

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return ((x >> S0_A) | (x << (WORD_W - S0_A)))
             ^ ((x >> S0_B) | (x << (WORD_W - S0_B)))
             ^ (x >> S0_C);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return ((x >> S1_A) | (x << (WORD_W - S1_A)))
             ^ ((x >> S1_B) | (x << (WORD_W - S1_B)))
             ^ (x >> S1_C);
    endfunction

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    t_q, t_d;
    logic [WORD_W-1:0]   wt_q, wt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                wt_v_q, wt_v_d;
    logic                done_q, done_d;
    logic [WORD_W-1:0]   ring_q [RING_N];

    logic                slot_free;
    logic                accept;
    logic                gen;
    logic                last_take;
    logic                ring_we;
    logic [WORD_W-1:0]   ring_wd;
    logic [RIDX_W-1:0]   ri_t, ri_m2, ri_m7, ri_m15;
    logic [WORD_W-1:0]   expand_w;

    // Handshake qualifiers
    assign slot_free = !wt_v_q || wt_yumi_i;
    assign accept    = (state_q == ST_LOAD) && m_v_i && slot_free;
    assign gen       = (state_q == ST_EXPAND) && slot_free && (t_q < CNT_W'(ROUNDS));
    assign last_take = (state_q == ST_EXPAND) && wt_yumi_i && wt_v_q
                       && (idx_q == IDX_W'(ROUNDS - 1));

    // Ring taps; 4-bit arithmetic gives the modulo-16 wrap for free
    assign ri_t     = t_q[RIDX_W-1:0];
    assign ri_m2    = ri_t - RIDX_W'(2);
    assign ri_m7    = ri_t - RIDX_W'(7);
    assign ri_m15   = ri_t - RIDX_W'(15);
    assign expand_w = sig1(ring_q[ri_m2]) + ring_q[ri_m7] + sig0(ring_q[ri_m15]) + ring_q[ri_t];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_LOAD;
            ST_LOAD:   if (accept && (t_q == CNT_W'(LAST_LD))) state_d = ST_EXPAND;
            ST_EXPAND: if (last_take) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next-state: a taken word drops valid unless a new one is loaded
    always_comb begin
        t_d     = t_q;
        wt_d    = wt_q;
        idx_d   = idx_q;
        wt_v_d  = wt_v_q && !wt_yumi_i;
        done_d  = 1'b0;
        ring_we = 1'b0;
        ring_wd = m_data_i;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) t_d = '0;
            end
            ST_LOAD: begin
                if (accept) begin
                    ring_we = 1'b1;
                    ring_wd = m_data_i;
                    wt_d    = m_data_i;
                    idx_d   = IDX_W'(t_q);
                    wt_v_d  = 1'b1;
                    t_d     = t_q + CNT_W'(1);
                end
            end
            ST_EXPAND: begin
                if (gen) begin
                    ring_we = 1'b1;
                    ring_wd = expand_w;
                    wt_d    = expand_w;
                    idx_d   = IDX_W'(t_q);
                    wt_v_d  = 1'b1;
                    t_d     = t_q + CNT_W'(1);
                end
                if (last_take) done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            t_q    <= '0;
            wt_q   <= '0;
            idx_q  <= '0;
            wt_v_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            t_q    <= t_d;
            wt_q   <= wt_d;
            idx_q  <= idx_d;
            wt_v_q <= wt_v_d;
            done_q <= done_d;
        end
    end

    // Ring contents are don't-care after reset, so no reset term here
    always_ff @(posedge clk_i) begin
        if (ring_we) begin
            ring_q[ri_t] <= ring_wd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(wt_yumi_i && !wt_v_q))
            else $error("sha2_msg_sched: wt_yumi_i asserted while wt_v_o is low");
        end
    end

    assign m_ready_o = (state_q == ST_LOAD) && slot_free;
    assign wt_v_o    = wt_v_q;
    assign wt_o      = wt_q;
    assign wt_idx_o  = idx_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = done_q;

endmodule
